// File: rtl/ds_operand_sequencer_pkg.sv
// Shared configuration for the digit-serial operand sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ds_operand_sequencer_pkg;

    // Default operand width and digit width.
    localparam int CFG_DATA_WIDTH = 8;
    localparam int CFG_N_DIGITAL  = 2;

    // Extra cycles beyond ITER that WAIT tolerates before declaring a timeout.
    localparam int WDOG_MARGIN    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_OUT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/ds_digit_shifter.sv
// Loadable left-shift register presenting an operand N_DIGITAL bits at a time, MSB digit first.
// Latency: digit_o shows the top digit of the loaded value the cycle after load_i.
// Backpressure: none; advances by one digit only on cycles where shift_i is high.
module ds_digit_shifter
    import ds_operand_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int N_DIGITAL  = CFG_N_DIGITAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] load_dat_i,
    output logic [N_DIGITAL-1:0]  digit_o
);

    logic [DATA_WIDTH-1:0] shreg_q;

    // Load has priority; otherwise move the next digit into the top slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_dat_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << N_DIGITAL;
        end
    end

    assign digit_o = shreg_q[DATA_WIDTH-1 -: N_DIGITAL];

endmodule

// File: rtl/ds_operand_sequencer.sv
// Sequences one a/g/b operand triple into a digit-serial multiplier and returns its product.
// Latency: start pulse 1 cycle after accept, ITER digit cycles, then result on mul_done or after ITER+4 WAIT cycles.
// Backpressure: in_ready only in IDLE; result held in OUT until out_ready, no combinational ready/valid paths.
module ds_operand_sequencer
    import ds_operand_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = CFG_DATA_WIDTH,
    parameter int N_DIGITAL  = CFG_N_DIGITAL,
    parameter int ITER       = DATA_WIDTH / N_DIGITAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_g,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_g,
    output logic [N_DIGITAL-1:0]  mul_b,
    input  logic                  mul_done,
    input  logic [DATA_WIDTH-1:0] mul_t,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_t,
    output logic                  err_timeout
);

    localparam int CNT_W = $clog2(ITER + WDOG_MARGIN + 1);
    localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(ITER + WDOG_MARGIN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Operands must split into a whole number of digits.
    if ((DATA_WIDTH % N_DIGITAL) != 0) begin : g_bad_digit_width
        $error("DATA_WIDTH must be a multiple of N_DIGITAL");
    end
    if ((ITER * N_DIGITAL) != DATA_WIDTH) begin : g_bad_iter
        $error("ITER must equal DATA_WIDTH / N_DIGITAL");
    end

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      k_q, k_d;
    logic [CNT_W-1:0]      wd_q, wd_d;
    logic [DATA_WIDTH-1:0] out_t_q, out_t_d;
    logic                  err_q, err_d;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] a_q, g_q;
    logic                  accept;
    logic                  feed;
    logic [N_DIGITAL-1:0]  digit;

    ds_digit_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_DIGITAL  (N_DIGITAL)
    ) u_digit_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .shift_i    (feed),
        .load_dat_i (in_b),
        .digit_o    (digit)
    );

    // Next-state, counters, result capture and sticky error.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wd_d    = wd_q;
        out_t_d = out_t_q;
        err_d   = err_q;
        accept  = 1'b0;
        feed    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    k_d     = '0;
                    wd_d    = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                k_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                feed = 1'b1;
                if (k_q != CNT_MAX) begin
                    k_d = k_q + CNT_W'(1);
                end
                if (mul_done) begin
                    // A completion before the last digit means the multiplier lost sync.
                    out_t_d = mul_t;
                    if (k_q != K_LAST) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_OUT;
                end else if (k_q == K_LAST) begin
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    out_t_d = mul_t;
                    state_d = ST_OUT;
                end else if (wd_q == WD_LAST) begin
                    out_t_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_OUT;
                end else if (wd_q != CNT_MAX) begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state; in_ready is registered so it stays low for the whole reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            wd_q       <= '0;
            out_t_q    <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wd_q       <= wd_d;
            out_t_q    <= out_t_d;
            err_q      <= err_d;
            in_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Operand latches, held stable for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            g_q <= '0;
        end else if (accept) begin
            a_q <= in_a;
            g_q <= in_g;
        end
    end

    assign in_ready    = in_ready_q;
    assign mul_start   = (state_q == ST_START);
    assign mul_a       = a_q;
    assign mul_g       = g_q;
    assign mul_b       = (state_q == ST_FEED) ? digit : '0;
    assign out_valid   = (state_q == ST_OUT);
    assign out_t       = out_t_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ds_operand_sequencer.sv
// Self-checking bench for ds_operand_sequencer with a timeline-level reference model.
// Latency: n/a.
// Backpressure: out_ready is scripted per scenario.
module tb_ds_operand_sequencer;

    localparam int DW   = 8;
    localparam int ND   = 2;
    localparam int IT   = DW / ND;
    localparam int WM   = 4;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_g = '0, in_b = '0;
    logic          mul_start;
    logic [DW-1:0] mul_a, mul_g;
    logic [ND-1:0] mul_b;
    logic          mul_done = 1'b0;
    logic [DW-1:0] mul_t = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_t;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ds_operand_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_g        (in_g),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_g       (mul_g),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_t       (mul_t),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_t       (out_t),
        .err_timeout (err_timeout)
    );

    // Per-cycle stimulus script
    bit            s_vld [MAXC];
    bit            s_done[MAXC];
    bit            s_ordy[MAXC];
    logic [DW-1:0] s_a[MAXC], s_g[MAXC], s_b[MAXC], s_t[MAXC];
    // Observed and expected traces
    logic          o_rdy[MAXC], o_start[MAXC], o_ovld[MAXC], o_err[MAXC];
    logic [ND-1:0] o_b[MAXC];
    logic [DW-1:0] o_t[MAXC], o_a[MAXC], o_g[MAXC];
    logic          e_rdy[MAXC], e_start[MAXC], e_ovld[MAXC], e_err[MAXC];
    logic [ND-1:0] e_b[MAXC];
    logic [DW-1:0] e_t[MAXC], e_a[MAXC], e_g[MAXC];
    // Reference-model architectural state carried between runs
    logic [DW-1:0] m_t = '0, m_a = '0, m_g = '0;
    logic          m_err = 1'b0;

    function automatic logic [ND-1:0] digit_of(input logic [DW-1:0] b, input int k);
        logic [DW-1:0] sh;
        sh = b >> (DW - ND * (k + 1));
        return sh[ND-1:0];
    endfunction

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            s_vld[c] = 1'b0; s_done[c] = 1'b0; s_ordy[c] = 1'b1;
            s_a[c] = $urandom; s_g[c] = $urandom; s_b[c] = $urandom; s_t[c] = $urandom;
        end
    endtask

    // Expected trace from the job timeline: accept, 1 start cycle, ITER digits,
    // up to ITER+WM wait cycles, then OUT until out_ready.
    task automatic model(input int n);
        int c, acc, wlast, d, ostart, r, fd_end, hi;
        logic [DW-1:0] tval;
        bit errset;
        for (int x = 0; x < n; x++) begin
            e_rdy[x] = 1'b1; e_start[x] = 1'b0; e_b[x] = '0; e_ovld[x] = 1'b0;
            e_t[x] = m_t; e_err[x] = m_err; e_a[x] = m_a; e_g[x] = m_g;
        end
        c = 0;
        while (c < n) begin
            if (!s_vld[c]) begin
                c++;
            end else begin
                acc   = c;
                wlast = acc + 2 + IT + IT + WM - 1;
                d     = -1;
                for (int x = acc + 2; x <= wlast && x < n; x++)
                    if (s_done[x] && d < 0) d = x;
                if (d >= 0) begin
                    ostart = d + 1; tval = s_t[d];
                    errset = (d < acc + 1 + IT);
                    fd_end = (d < acc + 1 + IT) ? d : acc + 1 + IT;
                end else begin
                    ostart = wlast + 1; tval = '0; errset = 1'b1; fd_end = acc + 1 + IT;
                end
                r = -1;
                for (int x = ostart; x < n; x++)
                    if (s_ordy[x] && r < 0) r = x;
                hi = (r < 0) ? n - 1 : r;
                for (int x = acc + 1; x < n; x++) begin
                    e_a[x] = s_a[acc]; e_g[x] = s_g[acc];
                end
                if (acc + 1 < n) e_start[acc + 1] = 1'b1;
                for (int x = acc + 1; x <= hi; x++) e_rdy[x] = 1'b0;
                for (int x = acc + 2; x <= fd_end && x < n; x++) e_b[x] = digit_of(s_b[acc], x - acc - 2);
                for (int x = ostart; x <= hi; x++) e_ovld[x] = 1'b1;
                for (int x = ostart; x < n; x++) begin
                    e_t[x] = tval;
                    if (errset) e_err[x] = 1'b1;
                end
                m_a = s_a[acc]; m_g = s_g[acc]; m_t = tval; m_err = m_err | errset;
                c = (r < 0) ? n : r + 1;
            end
        end
    endtask

    // Drive the script one cycle at a time, sampling outputs at the falling edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            o_rdy[c] = in_ready; o_start[c] = mul_start; o_b[c] = mul_b; o_ovld[c] = out_valid;
            o_t[c] = out_t; o_err[c] = err_timeout; o_a[c] = mul_a; o_g[c] = mul_g;
            in_valid = s_vld[c]; in_a = s_a[c]; in_g = s_g[c]; in_b = s_b[c];
            mul_done = s_done[c]; mul_t = s_t[c]; out_ready = s_ordy[c];
        end
        @(negedge clk);
        in_valid = 1'b0; mul_done = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mul_start, mul_b, mul_a, mul_g, out_valid, out_t, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_values rdy=%b start=%b b=%h a=%h g=%h vld=%b t=%h err=%b expected all zero",
                     in_ready, mul_start, mul_b, mul_a, mul_g, out_valid, out_t, err_timeout);
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_held got %b expected 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_release got %b expected 1", in_ready);
        end
        m_t = '0; m_a = '0; m_g = '0; m_err = 1'b0;
    endtask

    task automatic test_digit_feed();
        logic [ND-1:0] b4_digits [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        int nstart;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            s_vld[0] = 1'b1;
            if (it == 0) s_b[0] = 8'hB4;
            s_done[2 + IT + $urandom_range(0, 3)] = 1'b1;
            model(20);
            run(20);
            for (int c = 0; c < 20; c++) begin
                checks++;
                if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                    {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                    errors++;
                    $display("FAIL digit_feed it%0d cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                             it, c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                             e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
                end
            end
            if (it == 0) begin
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (o_b[2 + k] !== b4_digits[k]) begin
                        errors++; $display("FAIL b4_digit k=%0d got %0d expected %0d", k, o_b[2 + k], b4_digits[k]);
                    end
                end
                nstart = 0;
                for (int c = 0; c < 20; c++) if (o_start[c] === 1'b1) nstart++;
                checks++;
                if (nstart != 1) begin
                    errors++; $display("FAIL start_pulse_count got %0d expected 1", nstart);
                end
            end
        end
    endtask

    task automatic test_result_hold();
        clear_stim();
        s_vld[0] = 1'b1; s_a[0] = 8'h57; s_g[0] = 8'h1B;
        s_done[2 + IT + 2] = 1'b1; s_t[2 + IT + 2] = 8'hC1;
        for (int c = 0; c < 19; c++) s_ordy[c] = 1'b0;
        for (int c = 10; c < 19; c++) s_vld[c] = 1'b1;
        model(26);
        run(26);
        for (int c = 0; c < 26; c++) begin
            checks++;
            if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                errors++;
                $display("FAIL result_hold cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                         c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                         e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
            end
        end
        for (int c = 9; c <= 18; c++) begin
            checks++;
            if ({o_ovld[c], o_t[c], o_rdy[c]} !== {1'b1, 8'hC1, 1'b0}) begin
                errors++; $display("FAIL hold_c1 cyc%0d vld/t/rdy got %b/%h/%b expected 1/c1/0", c, o_ovld[c], o_t[c], o_rdy[c]);
            end
        end
        checks++;
        if (o_rdy[20] !== 1'b1) begin
            errors++; $display("FAIL ready_after_handshake got %b expected 1", o_rdy[20]);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, r1, n;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            d1 = $urandom_range(0, IT + WM - 1);
            d2 = $urandom_range(0, IT + WM - 1);
            s_vld[0] = 1'b1;
            s_done[2 + IT + d1] = 1'b1;
            r1 = 3 + IT + d1;
            s_vld[r1 + 1] = 1'b1;
            s_done[r1 + 1 + 2 + IT + d2] = 1'b1;
            n = r1 + 1 + 2 + IT + d2 + 4;
            model(n);
            run(n);
            for (int c = 0; c < n; c++) begin
                checks++;
                if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                    {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                    errors++;
                    $display("FAIL back_to_back it%0d cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                             it, c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                             e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
                end
            end
            checks++;
            if ({o_rdy[r1 + 1], o_start[r1 + 2]} !== 2'b11) begin
                errors++; $display("FAIL second_accept it%0d rdy/start got %b/%b expected 1/1", it, o_rdy[r1 + 1], o_start[r1 + 2]);
            end
        end
    endtask

    task automatic test_early_done();
        clear_stim();
        s_vld[0] = 1'b1;
        s_done[3] = 1'b1;
        model(12);
        run(12);
        for (int c = 0; c < 12; c++) begin
            checks++;
            if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                errors++;
                $display("FAIL early_done cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                         c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                         e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
            end
        end
        checks++;
        if ({o_err[3], o_err[4], o_ovld[4], o_t[4]} !== {1'b0, 1'b1, 1'b1, s_t[3]}) begin
            errors++; $display("FAIL early_err err3/err4/vld4/t4 got %b/%b/%b/%h expected 0/1/1/%h",
                               o_err[3], o_err[4], o_ovld[4], o_t[4], s_t[3]);
        end
    endtask

    task automatic test_timeout();
        int ow;
        clear_stim();
        s_vld[0] = 1'b1;
        ow = 2 + IT + IT + WM;
        model(20);
        run(20);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                errors++;
                $display("FAIL timeout cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                         c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                         e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
            end
        end
        checks++;
        if ({o_ovld[ow - 1], o_ovld[ow], o_t[ow], o_err[ow]} !== {1'b0, 1'b1, 8'h00, 1'b1}) begin
            errors++; $display("FAIL timeout_edge vld_before/vld/t/err got %b/%b/%h/%b expected 0/1/00/1",
                               o_ovld[ow - 1], o_ovld[ow], o_t[ow], o_err[ow]);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] b;
        b = $urandom;
        @(negedge clk);
        in_valid = 1'b1; in_a = $urandom; in_g = $urandom; in_b = b; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if (mul_b !== digit_of(b, 2)) begin
            errors++; $display("FAIL mid_reset_k2_digit got %h expected %h", mul_b, digit_of(b, 2));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, mul_start, mul_b, mul_a, mul_g, out_valid, out_t, err_timeout} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values rdy=%b start=%b b=%h a=%h g=%h vld=%b t=%h err=%b expected all zero",
                     in_ready, mul_start, mul_b, mul_a, mul_g, out_valid, out_t, err_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        m_t = '0; m_a = '0; m_g = '0; m_err = 1'b0;
        clear_stim();
        s_vld[0] = 1'b1;
        s_done[2 + IT + 1] = 1'b1;
        model(14);
        run(14);
        for (int c = 0; c < 14; c++) begin
            checks++;
            if ({o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c]} !==
                {e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]}) begin
                errors++;
                $display("FAIL clean_job cyc%0d rdy/start/b/vld/t/err/a/g got %b/%b/%h/%b/%h/%b/%h/%h expected %b/%b/%h/%b/%h/%b/%h/%h",
                         c, o_rdy[c], o_start[c], o_b[c], o_ovld[c], o_t[c], o_err[c], o_a[c], o_g[c],
                         e_rdy[c], e_start[c], e_b[c], e_ovld[c], e_t[c], e_err[c], e_a[c], e_g[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_feed();
        test_result_hold();
        test_back_to_back();
        test_early_done();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_operand_sequencer.md
DS_OPERAND_SEQUENCER -- requirements
Module: ds_operand_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH; operand and result width in bits.
REQ-002 Parameter N_DIGITAL, default `N_DIGITAL; digit width in bits.
REQ-003 Parameter ITER, default DATA_WIDTH/N_DIGITAL; number of digits per operand.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 in_valid  input  1  operand triple a/g/b is valid.
REQ-007 in_ready  output  1  sequencer accepts an operand triple this cycle.
REQ-008 in_a, in_g, in_b  input  DATA_WIDTH each  multiplicand, field polynomial, multiplier.
REQ-009 mul_start  output  1  one-cycle start pulse to the digit-serial multiplier wrapper.
REQ-010 mul_a, mul_g  output  DATA_WIDTH each  latched operands, held stable for the whole job.
REQ-011 mul_b  output  N_DIGITAL  current multiplier digit.
REQ-012 mul_done  input  1  multiplier completion flag.
REQ-013 mul_t  input  DATA_WIDTH  multiplier accumulator result.
REQ-014 out_valid  output  1  result is valid.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_t  output  DATA_WIDTH  captured product.
REQ-017 err_timeout  output  1  sticky watchdog error flag.

Function
REQ-018 The FSM SHALL implement exactly the states IDLE, START, FEED, WAIT and OUT.
REQ-019 in_ready SHALL equal 1 only in IDLE; an input is accepted when in_valid && in_ready, which latches a, g and b and moves the FSM to START.
REQ-020 START SHALL last one cycle: mul_start=1 and mul_b=0 during START, then the FSM moves to FEED with digit index k=0.
REQ-021 In FEED, mul_b SHALL equal in_b[DATA_WIDTH-1-k*N_DIGITAL -: N_DIGITAL] (MSB digit first), and k SHALL increment each cycle.
REQ-022 When k=ITER-1, the FSM SHALL move to WAIT on the next edge.
REQ-023 mul_b SHALL be 0 in every state other than FEED.
REQ-024 In FEED or WAIT, mul_done=1 SHALL capture mul_t into out_t and move the FSM to OUT.
REQ-025 A mul_done that arrives during FEED before the last digit SHALL also set err_timeout.
REQ-026 In WAIT, a watchdog SHALL count cycles; if mul_done is not seen within ITER+4 cycles of entering WAIT, err_timeout SHALL be set, out_t SHALL be loaded with 0, and the FSM SHALL move to OUT.
REQ-027 In OUT, out_valid SHALL be 1 and out_t SHALL hold stable until out_ready=1, and the FSM SHALL then move to IDLE.
REQ-028 Back-to-back operation: in_ready SHALL be 1 in the cycle after the out_valid && out_ready handshake.
REQ-029 There SHALL be no combinational path from in_valid to in_ready or from out_ready to out_valid.
REQ-030 err_timeout SHALL stay set until reset.
REQ-031 The digit counter and the watchdog counter SHALL each be $clog2(ITER+5) bits wide and SHALL saturate without wrap.
REQ-032 ITER SHALL be an integer; DATA_WIDTH mod N_DIGITAL != 0 SHALL be a parameter error that stops elaboration.

Reset
REQ-033 On rst_n=0 the block SHALL enter IDLE with all of the following cleared: in_ready=0 while reset is asserted, then 1; mul_start=0; mul_b=0; mul_a=0; mul_g=0; out_valid=0; out_t=0; err_timeout=0; both counters 0.
REQ-034 A reset asserted mid-job (START/FEED/WAIT/OUT) SHALL discard the job immediately, with no output handshake.

Structure
REQ-035 DATA_WIDTH, N_DIGITAL, the state encodings and the watchdog margin (4) SHALL live in the shared configuration header.
REQ-036 The sequencer SHALL be one module with one natural sub-module, ds_digit_shifter (a loadable left-shift register that emits the top N_DIGITAL bits and advances by N_DIGITAL per cycle).

Verification
REQ-037 DATA_WIDTH=8, N_DIGITAL=2, b=8'hB4 -> mul_b SHALL be 2,3,1,0 on FEED cycles 0..3 and mul_start SHALL pulse exactly once.
REQ-038 a=8'h57, g=8'h1B, model multiplier returning 8'hC1 with mul_done 2 cycles after WAIT -> out_valid=1 and out_t=8'hC1.
REQ-039 out_ready held 0 for 10 cycles -> out_valid and out_t SHALL stay stable, in_ready=0 throughout, and new in_valid SHALL be ignored.
REQ-040 mul_done never asserted -> err_timeout=1 and out_valid=1 with out_t=0 exactly ITER+4=8 cycles after WAIT entry.
REQ-041 rst_n pulsed low during FEED at k=2 -> all outputs SHALL be at reset values in the same cycle, and the next in_valid SHALL start a clean job with k=0.
REQ-042 Two back-to-back jobs with out_ready tied high -> the second in_valid SHALL be accepted one cycle after the first result handshake.
